alu_seq: RTL and testbench

Registered, parametrised ALU with a valid/ready handshake on both sides. It keeps the team's 4-bit alu_c encoding (ADD/SUB/AND/OR) and adds NOR, SLT, XOR and an iterative shift-add multiply. It produces full status flags and flags illegal opcodes. It sits between the decode/control stage and writeback, replacing the purely combinational ALU where multi-cycle ops and backpressure are needed.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_mul_iter.sv | 80 ++++++++
 rtl/alu_seq.sv | 181 ++++++++++++++++++
 tb/tb_alu_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - 4-bit alu_c opcode encodings (legacy ADD/SUB/AND/OR plus NOR, SLT,
//     XOR and the iterative MUL).
//   - FSM state encoding used by alu_seq.
//   - op_is_legal(): single source of truth for which opcodes are defined.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_XOR,
            OP_SUB, OP_SLT, OP_MUL, OP_NOR: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one partial product per cycle.
//   clk, rst_n   : clock, async active-low reset (discards any product in flight)
//   start_i      : load operands, clear accumulator/counter, begin iterating
//   a_i, b_i     : multiplicand / multiplier (sampled only with start_i)
//   busy_o       : iterations in progress
//   done_o       : one-cycle pulse; product_o is final while it is high
//   product_o    : full 2*WIDTH-bit product (accumulator)
module alu_mul_iter #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (start_i) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0])
                acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            // Last of WIDTH iterations: accumulator is final after this edge.
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on input and output.
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : input handshake; in_ready high only in IDLE
//   in1, in2, alu_c       : operands and opcode, sampled on the accept edge
//   out_valid / out_ready : output handshake; outputs held while stalled
//   result                : registered WIDTH-bit result
//   zero, negative        : result == 0, result MSB
//   carry                 : ADD/SUB carry-out (SUB: 1 = no borrow), MUL: high half != 0
//   overflow              : signed overflow for ADD/SUB
//   illegal               : opcode undefined (result forced to 0)
// Single-cycle ops finish on the accept edge; MUL goes through BUSY for
// WIDTH iterations plus one cycle to register the product.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       alu_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    state_t state_q, state_d;

    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             ill_q, ill_d;
    logic             load;

    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    // Single-cycle datapath (driven straight from the operand inputs; only
    // consumed on the accept edge).
    logic [WIDTH:0]   add_ext, sub_ext;
    logic             slt;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry, sc_ovf, sc_ill;

    alu_mul_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .a_i       (in1),
        .b_i       (in2),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    always_comb begin
        add_ext  = {1'b0, in1} + {1'b0, in2};
        // SUB as in1 + ~in2 + 1 so bit WIDTH is the "no borrow" carry.
        sub_ext  = {1'b0, in1} + {1'b0, ~in2} + {{WIDTH{1'b0}}, 1'b1};
        slt      = $signed(in1) < $signed(in2);
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_ill   = !op_is_legal(alu_c);
        case (alu_c)
            OP_AND: sc_res = in1 & in2;
            OP_OR:  sc_res = in1 | in2;
            OP_XOR: sc_res = in1 ^ in2;
            OP_NOR: sc_res = ~(in1 | in2);
            OP_ADD: begin
                sc_res   = add_ext[WIDTH-1:0];
                sc_carry = add_ext[WIDTH];
                sc_ovf   = (in1[WIDTH-1] == in2[WIDTH-1]) &&
                           (add_ext[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res   = sub_ext[WIDTH-1:0];
                sc_carry = sub_ext[WIDTH];
                sc_ovf   = (in1[WIDTH-1] != in2[WIDTH-1]) &&
                           (sub_ext[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, slt};
            default: sc_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        ill_d     = ill_q;
        load      = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (alu_c == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = BUSY;
                    end else begin
                        load     = 1'b1;
                        result_d = sc_res;
                        carry_d  = sc_carry;
                        ovf_d    = sc_ovf;
                        ill_d    = sc_ill;
                        state_d  = DONE;
                    end
                end
            end
            BUSY: begin
                if (mul_done) begin
                    load     = 1'b1;
                    result_d = mul_prod[WIDTH-1:0];
                    carry_d  = |mul_prod[2*WIDTH-1:WIDTH];
                    ovf_d    = 1'b0;
                    ill_d    = 1'b0;
                    state_d  = DONE;
                end else if (!mul_busy) begin
                    // Multiplier lost its job (cannot happen in normal flow);
                    // recover rather than hang.
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Status flags track the result being registered, not the inputs.
        zero_d = load ? (result_d == '0)        : zero_q;
        neg_d  = load ? result_d[WIDTH-1]       : neg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign negative  = neg_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [3:0]   alu_c;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         negative;
    logic         carry;
    logic         overflow;
    logic         illegal;

    int n_assert = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .alu_c     (alu_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single accept edge; returns just after that edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        alu_c    = op;
        in1      = a;
        in2      = b;
        step();
        in_valid = 1'b0;
        in1      = '0;
        in2      = '0;
        alu_c    = 4'b0000;
    endtask

    // Single-cycle op: check result/flags the cycle after accept, then drain.
    task automatic sc_op(input string tag, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic z, input logic n,
                         input logic c, input logic v, input logic il);
        issue(op, a, b);
        chk({tag, ".out_valid"}, W'(out_valid), W'(1));
        chk({tag, ".result"},    result,        res);
        chk({tag, ".zero"},      W'(zero),      W'(z));
        chk({tag, ".negative"},  W'(negative),  W'(n));
        chk({tag, ".carry"},     W'(carry),     W'(c));
        chk({tag, ".overflow"},  W'(overflow),  W'(v));
        chk({tag, ".illegal"},   W'(illegal),   W'(il));
        step();
        chk({tag, ".in_ready_after"}, W'(in_ready), W'(1));
    endtask

    initial begin
        int busy_bad;
        int ov_seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in1       = '0;
        in2       = '0;
        alu_c     = 4'b0000;
        out_ready = 1'b0;
        #12;
        chk("rst.in_ready",  W'(in_ready),  W'(1));
        chk("rst.out_valid", W'(out_valid), W'(0));
        chk("rst.result",    result,        W'(0));
        chk("rst.zero",      W'(zero),      W'(0));
        chk("rst.carry",     W'(carry),     W'(0));
        chk("rst.illegal",   W'(illegal),   W'(0));
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();

        // 1: ADD
        sc_op("add5_7", 4'b0010, 64'd5, 64'd7, 64'd12, 0, 0, 0, 0, 0);
        sc_op("add_ovf", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
              64'h8000_0000_0000_0000, 0, 1, 0, 1, 0);
        sc_op("add_wrap", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
              64'd0, 1, 0, 1, 0, 0);

        // 2: SUB
        sc_op("sub_ovf", 4'b0110, 64'h8000_0000_0000_0000, 64'd1,
              64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 1, 0);
        sc_op("sub3_3", 4'b0110, 64'd3, 64'd3, 64'd0, 1, 0, 1, 0, 0);
        sc_op("sub_borrow", 4'b0110, 64'd2, 64'd3,
              64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 0, 0);

        // 3: SLT
        sc_op("slt_m1_1", 4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 0, 0, 0, 0, 0);
        sc_op("slt_1_m1", 4'b0111, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0, 0, 0, 0);

        // Logic ops
        sc_op("and", 4'b0000, 64'hF0F0_0000_FFFF_1234, 64'hFF00_FF00_0F0F_00FF,
              64'hF000_0000_0F0F_0034, 0, 1, 0, 0, 0);
        sc_op("or", 4'b0001, 64'h0000_0000_0000_00F0, 64'h0000_0000_0000_000F,
              64'h0000_0000_0000_00FF, 0, 0, 0, 0, 0);
        sc_op("xor", 4'b0011, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA,
              64'd0, 1, 0, 0, 0, 0);
        sc_op("nor", 4'b1100, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_000F,
              64'hFFFF_FFFF_FFFF_FFF0, 0, 1, 0, 0, 0);

        // 4: MUL 2^32 * 2^32, latency and in_ready during BUSY
        issue(4'b1000, 64'h1_0000_0000, 64'h1_0000_0000);
        busy_bad = 0;
        for (int k = 1; k <= 64; k++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
            step();
        end
        // Sample 0 was just after accept; now 64 edges later, out_valid still low.
        chk("mul.busy_ready_valid_low", W'(busy_bad), W'(0));
        chk("mul.valid_low_at_64", W'(out_valid), W'(0));
        step();
        chk("mul.valid_at_65", W'(out_valid), W'(1));
        chk("mul.result",      result,        W'(0));
        chk("mul.zero",        W'(zero),      W'(1));
        chk("mul.carry",       W'(carry),     W'(1));
        chk("mul.overflow",    W'(overflow),  W'(0));
        step();
        chk("mul.in_ready_after", W'(in_ready), W'(1));

        // MUL 6*7
        issue(4'b1000, 64'd6, 64'd7);
        repeat (65) step();
        chk("mul67.valid",  W'(out_valid), W'(1));
        chk("mul67.result", result,        W'(42));
        chk("mul67.carry",  W'(carry),     W'(0));
        chk("mul67.zero",   W'(zero),      W'(0));
        step();

        // 5: Backpressure; junk on the inputs during DONE must be ignored
        out_ready = 1'b0;
        issue(4'b0010, 64'd1, 64'd1);
        in_valid = 1'b1;
        alu_c    = 4'b0110;
        in1      = 64'd100;
        in2      = 64'd1;
        for (int k = 0; k < 5; k++) begin
            chk("bp.out_valid", W'(out_valid), W'(1));
            chk("bp.result",    result,        W'(2));
            chk("bp.in_ready",  W'(in_ready),  W'(0));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp.release_in_ready",  W'(in_ready),  W'(1));
        chk("bp.release_out_valid", W'(out_valid), W'(0));
        chk("bp.result_kept",       result,        W'(2));

        // 6: illegal opcodes
        sc_op("ill_1111", 4'b1111, 64'd5, 64'd7, 64'd0, 1, 0, 0, 0, 1);
        sc_op("ill_0100", 4'b0100, 64'hFFFF, 64'd1, 64'd0, 1, 0, 0, 0, 1);
        sc_op("add9_9", 4'b0010, 64'd9, 64'd9, 64'd18, 0, 0, 0, 0, 0);

        // Reset in the middle of a MUL
        issue(4'b1000, 64'd3, 64'd5);
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        chk("rstmul.out_valid", W'(out_valid), W'(0));
        chk("rstmul.result",    result,        W'(0));
        chk("rstmul.in_ready",  W'(in_ready),  W'(1));
        #2;
        rst_n = 1'b1;
        ov_seen = 0;
        for (int k = 0; k < 80; k++) begin
            step();
            if (out_valid !== 1'b0) ov_seen++;
        end
        chk("rstmul.no_result", W'(ov_seen),   W'(0));
        chk("rstmul.idle",      W'(in_ready),  W'(1));
        chk("rstmul.result_0",  result,        W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
